// File: rtl/bcd_cnt_pkg.sv
// Shared BCD constants and the preset bound check used by the modulo counter.
package bcd_cnt_pkg;

  localparam int unsigned DigitW = 4;
  localparam logic [DigitW-1:0] DigitMax = 4'd9;

  // True when both digits are legal BCD and the decimal value lies in [min_v, max_v].
  function automatic logic bcd_in_range(input logic [DigitW-1:0] hi_d,
                                        input logic [DigitW-1:0] lo_d,
                                        input int unsigned       min_v,
                                        input int unsigned       max_v);
    int unsigned v;
    v = 32'(hi_d) * 32'd10 + 32'(lo_d);
    return (hi_d <= DigitMax) && (lo_d <= DigitMax) && (v >= min_v) && (v <= max_v);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD decade stepper: computes the next digit and a carry/borrow out.
module bcd_digit
  import bcd_cnt_pkg::*;
(
  input  logic [DigitW-1:0] d,
  input  logic              step,
  input  logic              up_dn,
  output logic [DigitW-1:0] nxt,
  output logic              co
);

  always_comb begin
    nxt = d;
    co  = 1'b0;
    if (step) begin
      if (up_dn) begin
        if (d == DigitMax) begin
          nxt = '0;
          co  = 1'b1;
        end else begin
          nxt = d + 4'd1;
        end
      end else begin
        if (d == '0) begin
          nxt = DigitMax;
          co  = 1'b1;
        end else begin
          nxt = d - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD up/down counter wrapping between MIN_VAL and MAX_VAL, with
// validated preset and a combinational terminal-count output for cascading.
module bcd_mod_counter
  import bcd_cnt_pkg::*;
#(
  parameter int unsigned MAX_VAL = 59,
  parameter int unsigned MIN_VAL = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              up_dn,
  input  logic              load,
  input  logic [DigitW-1:0] LD_H,
  input  logic [DigitW-1:0] LD_L,
  output logic [DigitW-1:0] CNT_L,
  output logic [DigitW-1:0] CNT_H,
  output logic              CAR,
  output logic              LD_ERR
);

  generate
    if (MAX_VAL > 99 || MIN_VAL >= MAX_VAL) begin : g_param_check
      $fatal(1, "bcd_mod_counter: need MIN_VAL < MAX_VAL <= 99");
    end
  endgenerate

  localparam logic [DigitW-1:0] MaxH = 4'(MAX_VAL / 10);
  localparam logic [DigitW-1:0] MaxL = 4'(MAX_VAL % 10);
  localparam logic [DigitW-1:0] MinH = 4'(MIN_VAL / 10);
  localparam logic [DigitW-1:0] MinL = 4'(MIN_VAL % 10);

  logic [DigitW-1:0] cnt_h_q, cnt_l_q;
  logic [DigitW-1:0] ones_nxt, tens_nxt;
  logic              ones_co, tens_co_unused;
  logic              ld_err_q;
  logic              at_max, at_min, wrap, ld_ok;

  bcd_digit u_ones (
    .d     (cnt_l_q),
    .step  (en),
    .up_dn (up_dn),
    .nxt   (ones_nxt),
    .co    (ones_co)
  );

  bcd_digit u_tens (
    .d     (cnt_h_q),
    .step  (ones_co),
    .up_dn (up_dn),
    .nxt   (tens_nxt),
    .co    (tens_co_unused)
  );

  always_comb begin
    at_max = (cnt_h_q == MaxH) && (cnt_l_q == MaxL);
    at_min = (cnt_h_q == MinH) && (cnt_l_q == MinL);
    wrap   = up_dn ? at_max : at_min;
    ld_ok  = bcd_in_range(LD_H, LD_L, MIN_VAL, MAX_VAL);
    CAR    = en & ~load & rst & wrap;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_h_q  <= MinH;
      cnt_l_q  <= MinL;
      ld_err_q <= 1'b0;
    end else begin
      ld_err_q <= 1'b0;
      if (load) begin
        if (ld_ok) begin
          cnt_h_q <= LD_H;
          cnt_l_q <= LD_L;
        end else begin
          ld_err_q <= 1'b1;
        end
      end else if (en) begin
        // The modulo bound overrides the plain decade chain at either end.
        if (wrap) begin
          cnt_h_q <= up_dn ? MinH : MaxH;
          cnt_l_q <= up_dn ? MinL : MaxL;
        end else begin
          cnt_h_q <= tens_nxt;
          cnt_l_q <= ones_nxt;
        end
      end
    end
  end

  assign CNT_H  = cnt_h_q;
  assign CNT_L  = cnt_l_q;
  assign LD_ERR = ld_err_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench: default and 1..12 counters, presets, reset override, two-stage cascade.
module tb_bcd_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_en, a_up, a_load;
  logic [3:0] a_ldh, a_ldl, a_cl, a_ch;
  logic       a_car, a_err;
  logic       b_en, b_up, b_load;
  logic [3:0] b_ldh, b_ldl, b_cl, b_ch;
  logic       b_car, b_err;
  logic       c_en;
  logic [3:0] lo_l, lo_h, hi_l, hi_h;
  logic       lo_car, hi_car, lo_err, hi_err;

  int checks = 0;
  int errors = 0;

  bcd_mod_counter u_a (
    .clk(clk), .rst(rst), .en(a_en), .up_dn(a_up), .load(a_load), .LD_H(a_ldh),
    .LD_L(a_ldl), .CNT_L(a_cl), .CNT_H(a_ch), .CAR(a_car), .LD_ERR(a_err)
  );

  bcd_mod_counter #(.MAX_VAL(12), .MIN_VAL(1)) u_b (
    .clk(clk), .rst(rst), .en(b_en), .up_dn(b_up), .load(b_load), .LD_H(b_ldh),
    .LD_L(b_ldl), .CNT_L(b_cl), .CNT_H(b_ch), .CAR(b_car), .LD_ERR(b_err)
  );

  bcd_mod_counter u_lo (
    .clk(clk), .rst(rst), .en(c_en), .up_dn(1'b1), .load(1'b0), .LD_H(4'd0),
    .LD_L(4'd0), .CNT_L(lo_l), .CNT_H(lo_h), .CAR(lo_car), .LD_ERR(lo_err)
  );

  bcd_mod_counter u_hi (
    .clk(clk), .rst(rst), .en(lo_car), .up_dn(1'b1), .load(1'b0), .LD_H(4'd0),
    .LD_L(4'd0), .CNT_L(hi_l), .CNT_H(hi_h), .CAR(hi_car), .LD_ERR(hi_err)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int va();
    return 10 * int'(a_ch) + int'(a_cl);
  endfunction

  function automatic int vb();
    return 10 * int'(b_ch) + int'(b_cl);
  endfunction

  function automatic int vlo();
    return 10 * int'(lo_h) + int'(lo_l);
  endfunction

  function automatic int vhi();
    return 10 * int'(hi_h) + int'(hi_l);
  endfunction

  initial begin
    int v;
    int prev_lo, prev_hi, wraps;
    logic lo_wrap;
    rst = 1'b0; c_en = 1'b0;
    a_en = 1'b0; a_up = 1'b1; a_load = 1'b0; a_ldh = '0; a_ldl = '0;
    b_en = 1'b0; b_up = 1'b1; b_load = 1'b0; b_ldh = '0; b_ldl = '0;
    tick();
    tick();
    check_eq("rst_a_val", va(), 0);
    check_eq("rst_a_err", int'(a_err), 0);
    check_eq("rst_b_val", vb(), 1);
    a_en = 1'b1; a_up = 1'b0;
    #1;
    check_eq("rst_car_low", int'(a_car), 0);
    a_en = 1'b0; a_up = 1'b1;
    rst = 1'b1;

    // 1..12 counter
    b_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      v = 1 + k;
      check_eq("b_car_up", int'(b_car), (v == 12) ? 1 : 0);
      tick();
      check_eq("b_up", vb(), (v == 12) ? 1 : v + 1);
    end
    b_up = 1'b0;
    #1;
    check_eq("b_car_dn_min", int'(b_car), 1);
    tick();
    check_eq("b_dn_wrap", vb(), 12);
    b_load = 1'b1; b_ldh = 4'd0; b_ldl = 4'd0;
    tick();
    check_eq("b_ld_below_min_val", vb(), 12);
    check_eq("b_ld_below_min_err", int'(b_err), 1);
    b_ldl = 4'd5;
    tick();
    check_eq("b_ld_ok_val", vb(), 5);
    check_eq("b_ld_ok_err", int'(b_err), 0);
    b_load = 1'b0; b_en = 1'b0;

    // Default 0..59 counter
    a_en = 1'b1; a_up = 1'b1;
    for (int i = 0; i < 60; i++) begin
      check_eq("a_car_up", int'(a_car), (i == 59) ? 1 : 0);
      tick();
      check_eq("a_up", va(), (i + 1) % 60);
    end
    a_up = 1'b0;
    #1;
    check_eq("a_car_dn", int'(a_car), 1);
    tick();
    check_eq("a_dn_wrap", va(), 59);
    a_up = 1'b1;
    #1;
    check_eq("a_car_dir", int'(a_car), 1);
    tick();
    check_eq("a_dir_change", va(), 0);

    a_load = 1'b1; a_ldh = 4'd4; a_ldl = 4'd5;
    #1;
    check_eq("a_car_load", int'(a_car), 0);
    tick();
    check_eq("a_load45", va(), 45);
    check_eq("a_load45_err", int'(a_err), 0);
    a_load = 1'b0;
    tick();
    check_eq("a_after_load", va(), 46);

    a_load = 1'b1; a_ldh = 4'd6; a_ldl = 4'd0;
    tick();
    check_eq("a_ld60_val", va(), 46);
    check_eq("a_ld60_err", int'(a_err), 1);
    a_load = 1'b0; a_en = 1'b0;
    tick();
    check_eq("a_ld60_err_clr", int'(a_err), 0);
    check_eq("a_ld60_hold", va(), 46);
    a_load = 1'b1; a_ldh = 4'd0; a_ldl = 4'd10;
    tick();
    check_eq("a_ld10_val", va(), 46);
    check_eq("a_ld10_err", int'(a_err), 1);
    a_load = 1'b0;
    tick();
    check_eq("a_ld10_err_clr", int'(a_err), 0);

    a_load = 1'b1; a_ldh = 4'd3; a_ldl = 4'd7;
    tick();
    check_eq("a_load37", va(), 37);
    rst = 1'b0; a_en = 1'b1; a_ldh = 4'd4; a_ldl = 4'd5;
    tick();
    check_eq("a_rst_val", va(), 0);
    check_eq("a_rst_err", int'(a_err), 0);
    check_eq("a_rst_car", int'(a_car), 0);
    rst = 1'b1; a_load = 1'b0;
    tick();
    check_eq("a_post_rst", va(), 1);
    a_en = 1'b0;

    // Cascade: seconds into minutes
    rst = 1'b0;
    tick();
    rst = 1'b1;
    c_en = 1'b1;
    wraps = 0;
    for (int n = 1; n <= 3600; n++) begin
      prev_lo = vlo();
      prev_hi = vhi();
      tick();
      lo_wrap = (prev_lo == 59) && (vlo() == 0);
      if (lo_wrap) check_eq("casc_hi_val", vhi(), (n / 60) % 60);
      if (prev_hi == 59 && vhi() == 0) begin
        wraps++;
        check_eq("casc_align", int'(lo_wrap), 1);
      end
    end
    check_eq("casc_wraps", wraps, 1);
    check_eq("casc_lo_end", vlo(), 0);
    check_eq("casc_hi_end", vhi(), 0);
    c_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
